// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;
  localparam int IMG_W  = DIGITS * SEG_W;

  localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

  typedef logic [1:0] digit_t;

  // Segment pattern of one digit; digit 0 is the rightmost, bit 0 = segment a.
  function automatic logic [SEG_W-1:0] seg_slice(input logic [IMG_W-1:0] img,
                                                 input digit_t idx);
    return img[int'(idx)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Image/control inputs and pin-side outputs of the scan driver.
interface seg7_scan_driver_if
  import seg7_pkg::*;
();

  logic [IMG_W-1:0]  seg_in;
  logic [DIGITS-1:0] blank_mask;
  logic [1:0]        bright;
  logic [DIGITS-1:0] an_n;
  logic [SEG_W-1:0]  seg_n;
  logic              frame_start;

  modport master (
    output seg_in, blank_mask, bright,
    input  an_n, seg_n, frame_start
  );

  modport slave (
    input  seg_in, blank_mask, bright,
    output an_n, seg_n, frame_start
  );

endinterface

// File: rtl/seg7_slot_counter.sv
// Slot/digit timebase; flags the one state per frame where inputs are captured.
module seg7_slot_counter
  import seg7_pkg::*;
#(
  parameter int SCAN_LOG2 = 3
) (
  input  logic                 sysclk,
  input  logic                 reset,
  output logic [SCAN_LOG2-1:0] cnt,
  output digit_t               digit,
  output logic                 capture
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt   <= '0;
      digit <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) digit <= digit + 1'b1;
    end
  end

  assign capture = (cnt == '0) && (digit == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Frame-buffered 4-digit scan driver with dead cycle, 2-bit PWM and per-digit blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_LOG2 = 3
) (
  input  logic               sysclk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  logic [SCAN_LOG2-1:0] cnt;
  digit_t               digit;
  logic                 capture;

  logic [IMG_W-1:0]  img_q;
  logic [DIGITS-1:0] mask_q;
  logic [1:0]        bright_q;
  logic [DIGITS-1:0] an_q;
  logic [SEG_W-1:0]  seg_q;
  logic              fs_q;
  logic [1:0]        pwm_phase;
  logic              lit;

  seg7_slot_counter #(.SCAN_LOG2(SCAN_LOG2)) u_slot (
    .sysclk  (sysclk),
    .reset   (reset),
    .cnt     (cnt),
    .digit   (digit),
    .capture (capture)
  );

  // Top two slot bits split the slot into quarters; cnt==0 is the anti-ghost dead cycle.
  assign pwm_phase = cnt[SCAN_LOG2-1 -: 2];
  assign lit       = (cnt != '0) && (pwm_phase <= bright_q) && !mask_q[digit];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      img_q    <= '0;
      mask_q   <= '0;
      bright_q <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      if (capture) begin
        img_q    <= bus.seg_in;
        mask_q   <= bus.blank_mask;
        bright_q <= bus.bright;
      end
      fs_q <= capture;
      if (lit) begin
        an_q  <= ~(4'b0001 << digit);
        seg_q <= ~seg_slice(img_q, digit);
      end else begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
      end
    end
  end

  assign bus.an_n        = an_q;
  assign bus.seg_n       = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Physical end of the clock's 28-bit display bus. Takes the 4-digit segment image that the display mux produces and time-multiplexes it onto one shared active-low segment bus plus 4 active-low digit anodes.
- Adds frame-synchronous buffering so the display never tears, a dead cycle per digit to stop ghosting, 2-bit brightness PWM and per-digit blanking.
- Sits between the display mux output and the board pins.

Parameters:
- SCAN_LOG2, default 3: log2 of cycles per digit slot. Must be at least 2. Slot length S = 2^SCAN_LOG2 cycles.

Ports:
- sysclk  in  1  system clock; every register is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  28  segment image. Digit i occupies bits [7i+6:7i]; digit 0 is the rightmost. Within a digit, bit 0 = segment a through bit 6 = segment g. 1 = segment lit.
- blank_mask  in  4  bit i = 1 forces digit i dark.
- bright  in  2  brightness level, 0 = dimmest, 3 = brightest.
- an_n  out  4  digit anodes, active-low, registered.
- seg_n  out  7  segments a..g, active-low, registered.
- frame_start  out  1  one-cycle pulse marking the frame-buffer capture.

Behaviour:
- Reset (reset high at an edge): cnt=0, digit=0, buf=0, mask_q=0, bright_q=0, an_n=4'hF, seg_n=7'h7F, frame_start=0. Reset wins over every other event. Asserting it mid-frame restarts the frame from digit 0 on the next cycle.
- Slot counter: cnt counts 0..S-1 and wraps. When cnt==S-1, digit increments 0,1,2,3,0...
- Frame: 4*S cycles. Default frame = 32 cycles.
- Capture: on an edge where cnt==0 and digit==0 (registered state), buf<=seg_in, mask_q<=blank_mask, bright_q<=bright, and frame_start<=1. On every other edge frame_start<=0.
- Input timing: inputs are sampled only at the capture point. Changes between captures have no effect until the next frame.
- "on" term, computed from the current registered state: (cnt != 0) AND (cnt[SCAN_LOG2-1:SCAN_LOG2-2] <= bright_q) AND (mask_q[digit]==0).
- Output update, every non-reset edge:
  - If on: an_n <= ~(4'b0001 << digit) and seg_n <= ~buf[7*digit+6 : 7*digit].
  - Otherwise: an_n <= 4'hF and seg_n <= 7'h7F.
- Output latency: outputs lag the state by 1 cycle.
  - cnt==0 is always dark (dead cycle), so buf updating on that same edge cannot glitch the display.
  - The first lit cycle of a frame already uses the new buf.
- On-cycles per slot at S=8:
  - bright=0: cnt 1 only, 1 cycle.
  - bright=1: cnt 1..3, 3 cycles.
  - bright=2: cnt 1..5, 5 cycles.
  - bright=3: cnt 1..7, 7 cycles.
- Invariants:
  - At most one an_n bit is low at any time.
  - When all an_n bits are high, seg_n==7'h7F.
- Reset release: an all-zero buf gives all segments off but still pulses anodes. frame_start first pulses on the edge after reset deasserts (state cnt=0, digit=0 at that point).
- seg_in all-ones with bright=3 and no blanking: each digit is lit S-1 of every S cycles.

Decomposition:
- Shared package seg7_pkg:
  - DIGITS=4, SEG_W=7.
  - SEG_OFF=7'h7F, AN_OFF=4'hF.
  - Function seg_slice(img, idx) returning the 7-bit slice.
- One sub-module is natural: seg7_slot_counter, which owns cnt, digit and the capture-strobe decode. Datapath, PWM compare and output registers stay in the top.

Test Plan:
- Reset then release, seg_in=28'h0, bright=3:
  - frame_start pulses every 32 cycles.
  - an_n cycles E,D,B,7, each low 7 of 8 cycles.
  - seg_n stays 7'h7F throughout.
- Digit mapping, seg_in={7'h06,7'h5B,7'h4F,7'h66}:
  - Digit 0 lit (an_n=E) shows seg_n=~7'h66.
  - Digit 3 lit (an_n=7) shows seg_n=~7'h06.
  - Every lit cycle shows exactly one low an_n bit.
- Brightness sweep 0..3: count lit cycles per slot. Required counts are 1, 3, 5, 7, changing only after the next frame_start.
- Mid-frame seg_in change at digit 1, cnt 4: the current frame keeps the old image; the new image appears from digit 0 cnt 1 of the next frame.
- blank_mask=4'b0101: digits 0 and 2 stay fully dark (an_n bits 0 and 2 never low); digits 1 and 3 are unaffected.
- Reset pulse of 1 cycle at digit 2, cnt 5:
  - Next cycle an_n=F and seg_n=7F.
  - frame_start follows on the next edge, then the frame restarts at digit 0.
